mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/brisc_mem_pkg.sv | 12 +
 rtl/mem_arbiter_rr_arb2.sv | 31 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brisc_mem_pkg.sv
// Shared types for the brisc memory arbiter: in-flight read tag and default RAM depth.
package brisc_mem_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4096;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_DATA  = 2'd2
    } rd_tag_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = fetch, bit 1 = data; data favoured after reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // prio_data_q = 1 means the data port wins the next conflict
    logic prio_data_q;

    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_data_q ? 2'b10 : 2'b01;
            default: gnt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_data_q <= 1'b1;
        end else if (update && (gnt != '0)) begin
            prio_data_q <= gnt[0];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data port arbiter in front of a single-port synchronous RAM, with grant
// and conflict performance counters.
module mem_arbiter
    import brisc_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_req,
    input  logic [31:0]              f_addr,
    output logic                     f_gnt,
    output logic                     f_rvalid,
    output logic [31:0]              f_rdata,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [31:0]              d_addr,
    input  logic [31:0]              d_wdata,
    output logic                     d_gnt,
    output logic                     d_rvalid,
    output logic [31:0]              d_rdata,
    output logic                     d_err,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    output logic [CNT_W-1:0]         cnt_f,
    output logic [CNT_W-1:0]         cnt_d,
    output logic [CNT_W-1:0]         cnt_conflict
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             conflict;
    logic             d_misalign;
    rd_tag_e          tag_q, tag_next;
    logic             err_q, err_next;
    logic [CNT_W-1:0] cnt_f_q, cnt_d_q, cnt_c_q;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{f_addr[31:AW+2], f_addr[1:0], d_addr[31:AW+2]};

    // Requests are masked during reset so nothing is granted and no state advances
    assign req        = {d_req & ~rst, f_req & ~rst};
    assign conflict   = req[0] & req[1];
    assign d_misalign = (d_addr[1:0] != 2'b00);

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update (|gnt),
        .gnt    (gnt)
    );

    assign f_gnt = gnt[0];
    assign d_gnt = gnt[1];

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tag_next  = TAG_NONE;
        err_next  = 1'b0;
        if (gnt[0]) begin
            mem_en   = 1'b1;
            mem_addr = f_addr[AW+1:2];
            tag_next = TAG_FETCH;
        end else if (gnt[1]) begin
            if (d_misalign) begin
                err_next = 1'b1;
            end else begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr[AW+1:2];
                mem_wdata = d_wdata;
                if (!d_we) begin
                    tag_next = TAG_DATA;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= TAG_NONE;
            err_q <= 1'b0;
        end else begin
            tag_q <= tag_next;
            err_q <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_f_q <= '0;
            cnt_d_q <= '0;
            cnt_c_q <= '0;
        end else begin
            if (gnt[0]) begin
                cnt_f_q <= cnt_f_q + CNT_ONE;
            end
            if (gnt[1]) begin
                cnt_d_q <= cnt_d_q + CNT_ONE;
            end
            if (conflict && (cnt_c_q != '1)) begin
                cnt_c_q <= cnt_c_q + CNT_ONE;
            end
        end
    end

    // Outputs are gated by rst so a read in flight at reset never reports
    assign f_rvalid     = (tag_q == TAG_FETCH) & ~rst;
    assign d_rvalid     = (tag_q == TAG_DATA) & ~rst;
    assign d_err        = err_q & ~rst;
    assign f_rdata      = f_rvalid ? mem_rdata : '0;
    assign d_rdata      = d_rvalid ? mem_rdata : '0;
    assign cnt_f        = rst ? '0 : cnt_f_q;
    assign cnt_d        = rst ? '0 : cnt_d_q;
    assign cnt_conflict = rst ? '0 : cnt_c_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, round-robin reference model
// and a response scoreboard checked every cycle.
module tb_mem_arbiter;

    localparam int DEPTH = 4096;
    localparam int CNT_W = 4;
    localparam int AW    = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0]      f_addr = '0, d_addr = '0, d_wdata = '0;
    logic             f_gnt, f_rvalid, d_gnt, d_rvalid, d_err;
    logic [31:0]      f_rdata, d_rdata;
    logic             mem_en, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [31:0]      mem_wdata, mem_rdata;
    logic [CNT_W-1:0] cnt_f, cnt_d, cnt_conflict;

    mem_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .cnt_f(cnt_f), .cnt_d(cnt_d), .cnt_conflict(cnt_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          fv;
        bit          dv;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    bit               prio_d = 1'b1;
    logic [CNT_W-1:0] ec_f = '0, ec_d = '0, ec_c = '0;
    logic [31:0]      model_mem [0:DEPTH-1];
    bit               dmy_f, dmy_d;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        return {16'hA5C3, 16'(i)};
    endfunction

    // Behavioural single-port RAM, 1-cycle read latency
    logic [31:0] ram [0:DEPTH-1];
    logic [31:0] ram_q;
    logic        ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    always @(posedge clk) cyc <= cyc + 1;

    // Response scoreboard: every cycle the read/err outputs must match the queue head or be idle
    always @(negedge clk) begin
        exp_t e;
        e = '{due: 0, fv: 1'b0, dv: 1'b0, err: 1'b0, data: 32'h0};
        if (sb.size() > 0 && sb[0].due == cyc) e = sb.pop_front();
        checks++;
        if ({f_rvalid, d_rvalid, d_err} !== {e.fv, e.dv, e.err}) begin
            errors++;
            $display("FAIL rsp_flags cyc=%0d f_rvalid,d_rvalid,d_err got=%b exp=%b",
                     cyc, {f_rvalid, d_rvalid, d_err}, {e.fv, e.dv, e.err});
        end
        checks++;
        if (f_rdata !== (e.fv ? e.data : 32'h0)) begin
            errors++;
            $display("FAIL f_rdata cyc=%0d got=%h exp=%h", cyc, f_rdata, e.fv ? e.data : 32'h0);
        end
        checks++;
        if (d_rdata !== (e.dv ? e.data : 32'h0)) begin
            errors++;
            $display("FAIL d_rdata cyc=%0d got=%h exp=%h", cyc, d_rdata, e.dv ? e.data : 32'h0);
        end
    end

    task automatic do_cycle(input bit fr, input logic [31:0] fa, input bit dr, input bit dwe,
                            input logic [31:0] da, input logic [31:0] dwd,
                            output bit gf, output bit gd);
        bit            mis, een, ewe;
        logic [AW-1:0] ea;
        exp_t          e;
        f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        gf  = fr && (!dr || !prio_d);
        gd  = dr && (!fr || prio_d);
        mis = gd && (da[1:0] != 2'b00);
        een = gf || (gd && !mis);
        ewe = gd && !mis && dwe;
        ea  = gf ? fa[AW+1:2] : da[AW+1:2];
        @(negedge clk);
        checks++;
        if ({f_gnt, d_gnt} !== {gf, gd}) begin
            errors++;
            $display("FAIL grant cyc=%0d f_gnt,d_gnt got=%b exp=%b", cyc, {f_gnt, d_gnt}, {gf, gd});
        end
        checks++;
        if ({mem_en, mem_we} !== {een, ewe}) begin
            errors++;
            $display("FAIL mem_ctl cyc=%0d mem_en,mem_we got=%b exp=%b", cyc, {mem_en, mem_we}, {een, ewe});
        end
        if (een) begin
            checks++;
            if (mem_addr !== ea) begin
                errors++;
                $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, ea);
            end
        end
        if (ewe) begin
            checks++;
            if (mem_wdata !== dwd) begin
                errors++;
                $display("FAIL mem_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, dwd);
            end
        end
        e = '{due: cyc + 1, fv: 1'b0, dv: 1'b0, err: 1'b0, data: 32'h0};
        if (gf) begin
            e.fv = 1'b1; e.data = model_mem[ea];
            sb.push_back(e);
        end else if (gd && mis) begin
            e.err = 1'b1;
            sb.push_back(e);
        end else if (gd && !dwe) begin
            e.dv = 1'b1; e.data = model_mem[ea];
            sb.push_back(e);
        end else if (gd) begin
            model_mem[ea] = dwd;
        end
        if (gf || gd) prio_d = gf;
        if (gf) ec_f++;
        if (gd) ec_d++;
        if (fr && dr && ec_c != '1) ec_c++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, dmy_f, dmy_d);
    endtask

    task automatic apply_reset();
        rst = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = 32'h10; d_addr = 32'h20;
        sb.delete();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({f_gnt, d_gnt, mem_en, mem_we} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ctl gnt/mem got=%b exp=0000", {f_gnt, d_gnt, mem_en, mem_we});
            end
            checks++;
            if ({cnt_f, cnt_d, cnt_conflict} !== '0) begin
                errors++;
                $display("FAIL reset_cnt got=%h/%h/%h exp=0/0/0", cnt_f, cnt_d, cnt_conflict);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; f_req = 1'b0; d_req = 1'b0;
        prio_d = 1'b1; ec_f = '0; ec_d = '0; ec_c = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        idle(2);
    endtask

    task automatic test_fetch_read();
        do_cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, dmy_f, dmy_d);
        idle(1);
        checks++;
        if (cnt_f !== 4'd1) begin
            errors++;
            $display("FAIL fetch_cnt got=%0d exp=1", cnt_f);
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        repeat (4) do_cycle(1'b1, 32'h10, 1'b1, 1'b0, 32'h24, 32'h0, dmy_f, dmy_d);
        idle(1);
        checks++;
        if ({cnt_conflict, cnt_f, cnt_d} !== {4'd4, 4'd2, 4'd2}) begin
            errors++;
            $display("FAIL conflict_cnt got=%0d/%0d/%0d exp=4/2/2", cnt_conflict, cnt_f, cnt_d);
        end
    endtask

    task automatic test_write_read();
        do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, dmy_f, dmy_d);
        do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, dmy_f, dmy_d);
        idle(1);
    endtask

    task automatic test_misaligned();
        do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h22, 32'h0, dmy_f, dmy_d);
        do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h33, 32'hCAFEF00D, dmy_f, dmy_d);
        do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, dmy_f, dmy_d);
        idle(1);
    endtask

    task automatic test_reset_inflight();
        do_cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, dmy_f, dmy_d);
        rst = 1'b1; f_req = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({f_rvalid, cnt_f, cnt_d, cnt_conflict} !== '0) begin
            errors++;
            $display("FAIL reset_inflight got f_rvalid=%b cnt=%0d/%0d/%0d exp 0",
                     f_rvalid, cnt_f, cnt_d, cnt_conflict);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        prio_d = 1'b1; ec_f = '0; ec_d = '0; ec_c = '0;
        @(negedge clk);
        checks++;
        if ({f_rvalid, cnt_f, cnt_d, cnt_conflict} !== '0) begin
            errors++;
            $display("FAIL post_reset got f_rvalid=%b cnt=%0d/%0d/%0d exp 0",
                     f_rvalid, cnt_f, cnt_d, cnt_conflict);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_addr_wrap();
        do_cycle(1'b1, 32'h4004, 1'b0, 1'b0, 32'h0, 32'h0, dmy_f, dmy_d);
        do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_C008, 32'h0, dmy_f, dmy_d);
        idle(1);
    endtask

    task automatic test_counters_saturate();
        apply_reset();
        for (int i = 0; i < 20; i++)
            do_cycle(1'b1, 32'(i * 4), 1'b1, 1'b0, 32'(32'h100 + i * 4), 32'h0, dmy_f, dmy_d);
        checks++;
        if ({cnt_conflict, cnt_f, cnt_d} !== {4'd15, 4'd10, 4'd10}) begin
            errors++;
            $display("FAIL sat_cnt got=%0d/%0d/%0d exp=15/10/10", cnt_conflict, cnt_f, cnt_d);
        end
        for (int i = 0; i < 8; i++)
            do_cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, dmy_f, dmy_d);
        do_cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, dmy_f, dmy_d);
        idle(1);
        checks++;
        if ({cnt_conflict, cnt_f} !== {4'd15, 4'd2}) begin
            errors++;
            $display("FAIL wrap_cnt got=%0d/%0d exp=15/2", cnt_conflict, cnt_f);
        end
        checks++;
        if ({cnt_f, cnt_d, cnt_conflict} !== {ec_f, ec_d, ec_c}) begin
            errors++;
            $display("FAIL model_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     cnt_f, cnt_d, cnt_conflict, ec_f, ec_d, ec_c);
        end
    endtask

    task automatic test_back_to_back();
        bit          fr = 0, dr = 0, dwe = 0, gf, gd;
        logic [31:0] fa = '0, da = '0, dwd = '0;
        for (int i = 0; i < 60; i++) begin
            if (!fr) begin
                fr = ($urandom_range(0, 3) != 0);
                fa = {$urandom_range(0, 63), 2'b00};
            end
            if (!dr) begin
                dr  = ($urandom_range(0, 3) != 0);
                dwe = $urandom_range(0, 1);
                da  = {$urandom_range(0, 63), ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00};
                dwd = $urandom;
            end
            do_cycle(fr, fa, dr, dwe, da, dwd, gf, gd);
            if (gf) fr = 0;
            if (gd) dr = 0;
        end
        idle(1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);
        test_reset();
        test_fetch_read();
        test_conflict();
        test_write_read();
        test_misaligned();
        test_reset_inflight();
        test_addr_wrap();
        test_counters_saturate();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout bench did not complete got=running exp=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
